// File: rtl/sd_spi_response_transmitter.sv
// ============================================================================
//  Module   : sd_spi_response_transmitter
//  Purpose  : SD-over-SPI slave MISO path. It decodes each command, tracks the
//             idle and APP_CMD state, and streams the Ncr fill and R1/R3/R7 bytes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_response_transmitter #(
    parameter int          NCR_BYTES     = 1,
    parameter int          ACMD41_POLLS  = 2,
    parameter logic [31:0] OCR           = 32'h00FF8000,
    parameter int          MAX_BLOCK_LEN = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandValid,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_ByteRequest,
    output logic [7:0]  io_OutputBuffer,
    output logic        io_Busy,
    output logic        io_InIdle,
    output logic        io_AppCmd
);

    localparam int          PW        = (ACMD41_POLLS < 1) ? 1 : $clog2(ACMD41_POLLS + 1);
    localparam logic [PW:0] POLLS_EXT = (PW + 1)'(ACMD41_POLLS);
    localparam logic [31:0] MAX_LEN   = 32'(MAX_BLOCK_LEN);
    localparam logic [3:0]  NCR_INIT  = 4'(NCR_BYTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_NCR     = 2'd1,
        S_R1      = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t        state_q;
    logic [7:0]    out_q;
    logic [7:0]    r1_q;
    logic [31:0]   payload_q;
    logic          has_payload_q;
    logic [3:0]    ncr_cnt_q;
    logic [1:0]    idx_q;
    logic          in_idle_q;
    logic          app_cmd_q;
    logic [PW-1:0] poll_q;

    logic          dec_param_err;
    logic          dec_illegal;
    logic          dec_has_payload;
    logic [31:0]   dec_payload;
    logic          dec_idle;
    logic [PW-1:0] dec_poll;
    logic [PW:0]   poll_inc;
    logic [7:0]    dec_r1;

    // Decode is purely combinational; it is committed only when a command is accepted in IDLE.
    always_comb begin
        dec_param_err   = 1'b0;
        dec_illegal     = 1'b0;
        dec_has_payload = 1'b0;
        dec_payload     = 32'h0;
        dec_idle        = in_idle_q;
        dec_poll        = poll_q;
        poll_inc        = {1'b0, poll_q} + {{PW{1'b0}}, 1'b1};
        case (io_Command)
            6'd0: begin
                dec_idle = 1'b1;
                dec_poll = '0;
            end
            6'd8: begin
                dec_has_payload = 1'b1;
                dec_payload     = {20'h0, (io_CommandArgument[11:8] == 4'h1) ? 4'h1 : 4'h0,
                                   io_CommandArgument[7:0]};
            end
            6'd16: begin
                dec_param_err = (io_CommandArgument == 32'h0) || (io_CommandArgument > MAX_LEN);
            end
            6'd55: begin
                dec_illegal = 1'b0;
            end
            6'd41: begin
                if (app_cmd_q) begin
                    if (poll_inc >= POLLS_EXT) begin
                        dec_idle = 1'b0;
                        dec_poll = POLLS_EXT[PW-1:0];
                    end else begin
                        dec_poll = poll_inc[PW-1:0];
                    end
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            6'd58: begin
                dec_has_payload = 1'b1;
                dec_payload     = {~in_idle_q, 1'b0, OCR[29:0]};
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        dec_r1 = {1'b0, dec_param_err, 3'b000, dec_illegal, 1'b0, dec_idle};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            out_q         <= 8'hFF;
            r1_q          <= 8'h00;
            payload_q     <= 32'h0;
            has_payload_q <= 1'b0;
            ncr_cnt_q     <= 4'd0;
            idx_q         <= 2'd0;
            in_idle_q     <= 1'b1;
            app_cmd_q     <= 1'b0;
            poll_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_q <= 8'hFF;
                    if (io_CommandValid) begin
                        r1_q          <= dec_r1;
                        payload_q     <= dec_payload;
                        has_payload_q <= dec_has_payload;
                        in_idle_q     <= dec_idle;
                        poll_q        <= dec_poll;
                        app_cmd_q     <= (io_Command == 6'd55);
                        ncr_cnt_q     <= NCR_INIT;
                        state_q       <= S_NCR;
                    end
                end
                S_NCR: begin
                    if (io_ByteRequest) begin
                        if (ncr_cnt_q == 4'd1) begin
                            out_q   <= r1_q;
                            state_q <= S_R1;
                        end else begin
                            ncr_cnt_q <= ncr_cnt_q - 4'd1;
                        end
                    end
                end
                S_R1: begin
                    if (io_ByteRequest) begin
                        if (has_payload_q) begin
                            out_q     <= payload_q[31:24];
                            payload_q <= {payload_q[23:0], 8'h00};
                            idx_q     <= 2'd0;
                            state_q   <= S_PAYLOAD;
                        end else begin
                            out_q   <= 8'hFF;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (io_ByteRequest) begin
                        if (idx_q == 2'd3) begin
                            out_q   <= 8'hFF;
                            state_q <= S_IDLE;
                        end else begin
                            out_q     <= payload_q[31:24];
                            payload_q <= {payload_q[23:0], 8'h00};
                            idx_q     <= idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= 8'hFF;
                end
            endcase
        end
    end

    assign io_OutputBuffer = out_q;
    assign io_Busy         = (state_q != S_IDLE);
    assign io_InIdle       = in_idle_q;
    assign io_AppCmd       = app_cmd_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_response_transmitter.sv
// ============================================================================
//  Module   : tb_sd_spi_response_transmitter
//  Purpose  : Directed and random command streams for sd_spi_response_transmitter,
//             compared against a byte-queue reference of the SD card state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_response_transmitter;

    localparam int          NCR   = 1;
    localparam int          POLLS = 2;
    localparam logic [31:0] OCR_V = 32'h00FF8000;
    localparam int          MAXBL = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [5:0]  cmd = 6'd0;
    logic [31:0] arg = 32'd0;
    logic        byte_req = 1'b0;
    logic [7:0]  out_buf;
    logic        busy;
    logic        in_idle;
    logic        app_cmd;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference card state and the byte stream still owed to the host
    bit       m_idle = 1'b1;
    bit       m_app  = 1'b0;
    int       m_poll = 0;
    logic [7:0] exp_q[$];

    sd_spi_response_transmitter #(
        .NCR_BYTES    (NCR),
        .ACMD41_POLLS (POLLS),
        .OCR          (OCR_V),
        .MAX_BLOCK_LEN(MAXBL)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_CommandValid   (cmd_valid),
        .io_Command        (cmd),
        .io_CommandArgument(arg),
        .io_ByteRequest    (byte_req),
        .io_OutputBuffer   (out_buf),
        .io_Busy           (busy),
        .io_InIdle         (in_idle),
        .io_AppCmd         (app_cmd)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_app  = 1'b0;
        m_poll = 0;
        exp_q.delete();
    endtask

    // Applies the card rules to one accepted command and queues the bytes it owes.
    task automatic model_cmd(input int c, input logic [31:0] a);
        int          perr = 0;
        int          ill  = 0;
        int          plen = 0;
        logic [31:0] pay  = 32'd0;
        int          r1;
        case (c)
            0:  begin m_idle = 1'b1; m_poll = 0; end
            8:  begin plen = 4; pay = ((((a >> 8) & 15) == 1) ? 256 : 0) + (a & 255); end
            16: perr = (a == 0 || a > MAXBL) ? 1 : 0;
            55: ;
            41: begin
                if (m_app) begin
                    if (m_poll + 1 >= POLLS) m_idle = 1'b0;
                    m_poll = (m_poll + 1 > POLLS) ? POLLS : m_poll + 1;
                end else begin
                    ill = 1;
                end
            end
            58: begin plen = 4; pay = (m_idle ? 32'h0 : 32'h8000_0000) + (OCR_V % 32'h4000_0000); end
            default: ill = 1;
        endcase
        m_app = (c == 55);
        r1 = perr * 64 + ill * 4 + (m_idle ? 1 : 0);
        exp_q.delete();
        for (int i = 0; i < NCR; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'(r1));
        for (int i = plen - 1; i >= 0; i--) exp_q.push_back(8'(pay / (32'd1 << (8 * i))));
    endtask

    task automatic send(input int c, input logic [31:0] a, input bit req_same);
        cmd_valid = 1'b1;
        cmd       = 6'(c);
        arg       = a;
        byte_req  = req_same;
        cyc();
        cmd_valid = 1'b0;
        byte_req  = 1'b0;
        model_cmd(c, a);
    endtask

    task automatic req();
        byte_req = 1'b1;
        cyc();
        byte_req = 1'b0;
    endtask

    // Consumes up to n queued bytes, checking each before the shifter takes it.
    task automatic drain(input string tag, input int n, input int max_gap);
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            repeat ($urandom_range(0, max_gap)) cyc();
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".byte"}, 32'(out_buf), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            req();
        end
    endtask

    task automatic finish_resp(input string tag, input int max_gap);
        drain(tag, 64, max_gap);
        chk({tag, ".end_busy"}, 32'(busy), 32'd0);
        chk({tag, ".end_byte"}, 32'(out_buf), 32'h0000_00FF);
        chk({tag, ".idle"}, 32'(in_idle), 32'(m_idle));
        chk({tag, ".app"}, 32'(app_cmd), 32'(m_app));
    endtask

    task automatic run(input string tag, input int c, input logic [31:0] a);
        send(c, a, 1'b0);
        finish_resp(tag, 0);
    endtask

    initial begin
        int c;
        logic [31:0] a;

        // T1: reset state then CMD0
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst.byte", 32'(out_buf), 32'h0000_00FF);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.idle", 32'(in_idle), 32'd1);
        chk("rst.app", 32'(app_cmd), 32'd0);
        send(0, 32'd0, 1'b0);
        chk("t1.q0", 32'(exp_q[1]), 32'h01);
        finish_resp("t1", 0);

        // T2: CMD8 check pattern echo
        run("t2", 8, 32'h0000_01AA);
        chk("t2.idle_const", 32'(in_idle), 32'd1);

        // T3: illegal CMD41, then ACMD41 init sequence
        send(41, 32'd0, 1'b0);
        chk("t3.r1_illegal", 32'(exp_q[1]), 32'h05);
        finish_resp("t3a", 0);
        run("t3b", 55, 32'd0);
        run("t3c", 41, 32'h4000_0000);
        run("t3d", 55, 32'd0);
        run("t3e", 41, 32'h4000_0000);
        chk("t3.idle_const", 32'(in_idle), 32'd0);
        chk("t3.app_const", 32'(app_cmd), 32'd0);

        // T4: OCR read and block length limits
        run("t4a", 58, 32'd0);
        run("t4b", 16, 32'd0);
        run("t4c", 16, 32'd512);
        run("t4d", 16, 32'd513);

        // T5: command during payload is ignored
        send(8, 32'h0000_0155, 1'b0);
        drain("t5a", 3, 1);
        cmd_valid = 1'b1; cmd = 6'd0; arg = 32'd0;
        cyc();
        cmd_valid = 1'b0;
        chk("t5.idle_kept", 32'(in_idle), 32'(m_idle));
        finish_resp("t5b", 1);

        // Random command mix, gaps and same-cycle requests
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: c = 0;
                1: c = 8;
                2: c = 16;
                3, 4: c = 55;
                5: c = 41;
                6: c = 58;
                default: c = int'($urandom_range(0, 63));
            endcase
            a = $urandom;
            if (c == 16) begin
                case ($urandom_range(0, 3))
                    0: a = 32'd0;
                    1: a = 32'd512;
                    2: a = 32'd513;
                    default: a = 32'($urandom_range(1, 1024));
                endcase
            end
            if (c == 8 && $urandom_range(0, 1) == 1) a = (a & 32'hFFFF_F0FF) | 32'h100;
            send(c, a, 1'($urandom_range(0, 1)));
            finish_resp("rnd", 2);
        end

        // T6: reset in the middle of a payload
        run("t6a", 55, 32'd0);
        send(8, 32'h0000_01AA, 1'b0);
        drain("t6b", 3, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_reset();
        chk("t6.byte", 32'(out_buf), 32'h0000_00FF);
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.idle", 32'(in_idle), 32'd1);
        chk("t6.app", 32'(app_cmd), 32'd0);
        run("t6c", 41, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
